// File: rtl/qdrc_phy_train_pattern_gen.sv
// QDR PHY training pattern generator.
// Writes a rise=ones / fall=zeros DDR pattern to one address, settles, then
// streams back-to-back reads of that address while the per-bit read trainer
// runs. Reports sticky done/fail once the trainer finishes or the read phase
// times out.
module qdrc_phy_train_pattern_gen #(
    parameter int DATA_WIDTH     = 36,
    parameter int ADDR_WIDTH     = 22,
    parameter int BW_WIDTH       = 4,
    parameter int TRAIN_ADDR     = 0,
    parameter int SETTLE_CYCLES  = 16,
    parameter int READ_LEAD      = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  train_start,
    input  logic                  bit_train_done,
    input  logic                  bit_train_fail,
    output logic                  bit_train_start,
    output logic                  qdr_w_n,
    output logic                  qdr_r_n,
    output logic [ADDR_WIDTH-1:0] qdr_sa,
    output logic [DATA_WIDTH-1:0] qdr_d_rise,
    output logic [DATA_WIDTH-1:0] qdr_d_fall,
    output logic [BW_WIDTH-1:0]   qdr_bw_n,
    output logic                  train_done,
    output logic                  train_fail,
    output logic [2:0]            state_prb
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE_CMD  = 3'd1,
        ST_WRITE_DATA = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_READ       = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] TRAIN_SA    = ADDR_WIDTH'(TRAIN_ADDR);
    // SETTLE is entered one cycle after WRITE_DATA, so the last settle cycle
    // carries count SETTLE_CYCLES-2; unused when SETTLE_CYCLES is 1.
    localparam logic [7:0]            SETTLE_LAST = 8'(SETTLE_CYCLES - 2);
    localparam logic [15:0]           LEAD_CNT    = 16'(READ_LEAD);
    localparam logic [15:0]           TIMEOUT_CNT = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic [7:0]  settle_cnt;
    // read_cnt holds the 1-based index of the read command on the bus now;
    // the timeout compare happens before any increment, so it never wraps.
    logic [15:0] read_cnt;
    // Set together with the start pulse; done from the trainer is only
    // honoured once the trainer has actually been started.
    logic        started;

    assign state_prb = state;

    // Sequencer: next state and all bus/status outputs registered together,
    // so every output reflects the state it is shown alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            settle_cnt      <= 8'd0;
            read_cnt        <= 16'd0;
            started         <= 1'b0;
            bit_train_start <= 1'b0;
            qdr_w_n         <= 1'b1;
            qdr_r_n         <= 1'b1;
            qdr_sa          <= '0;
            qdr_d_rise      <= '0;
            qdr_d_fall      <= '0;
            qdr_bw_n        <= '1;
            train_done      <= 1'b0;
            train_fail      <= 1'b0;
        end else begin
            // Idle bus unless the next state drives it.
            bit_train_start <= 1'b0;
            qdr_w_n         <= 1'b1;
            qdr_r_n         <= 1'b1;
            qdr_sa          <= '0;
            qdr_d_rise      <= '0;
            qdr_d_fall      <= '0;
            qdr_bw_n        <= '1;
            case (state)
                ST_IDLE: begin
                    if (train_start) begin
                        state    <= ST_WRITE_CMD;
                        qdr_w_n  <= 1'b0;
                        qdr_sa   <= TRAIN_SA;
                        qdr_bw_n <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE_CMD: begin
                    state      <= ST_WRITE_DATA;
                    qdr_d_rise <= '1;
                    qdr_d_fall <= '0;
                    qdr_bw_n   <= '0;
                end
                ST_WRITE_DATA: begin
                    settle_cnt <= 8'd0;
                    if (SETTLE_CYCLES == 1) begin
                        state    <= ST_READ;
                        qdr_r_n  <= 1'b0;
                        qdr_sa   <= TRAIN_SA;
                        read_cnt <= 16'd1;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state    <= ST_READ;
                        qdr_r_n  <= 1'b0;
                        qdr_sa   <= TRAIN_SA;
                        read_cnt <= 16'd1;
                    end else begin
                        state      <= ST_SETTLE;
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_READ: begin
                    if (started && bit_train_done) begin
                        state      <= ST_DONE;
                        train_done <= 1'b1;
                        train_fail <= bit_train_fail;
                    end else if (read_cnt == TIMEOUT_CNT) begin
                        state      <= ST_DONE;
                        train_done <= 1'b1;
                        train_fail <= 1'b1;
                    end else begin
                        state    <= ST_READ;
                        qdr_r_n  <= 1'b0;
                        qdr_sa   <= TRAIN_SA;
                        read_cnt <= read_cnt + 16'd1;
                        if (read_cnt == LEAD_CNT && !started) begin
                            bit_train_start <= 1'b1;
                            started         <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qdrc_phy_train_pattern_gen.sv
// Self-checking bench for qdrc_phy_train_pattern_gen: a cycle-position model
// of the training sequence checked against the DUT every cycle, plus literal
// timing checks derived from the observed bus activity.
module tb_qdrc_phy_train_pattern_gen;

    localparam int DW      = 36;
    localparam int AW      = 22;
    localparam int BW      = 4;
    localparam int SETTLE  = 16;
    localparam int LEAD    = 32;
    localparam int TIMEOUT = 200;
    // Cycle positions relative to the WRITE_CMD cycle (position 1).
    localparam int READ_K0 = 2 + SETTLE;
    localparam int PULSE_K = READ_K0 + LEAD;

    logic          clk;
    logic          reset;
    logic          train_start;
    logic          bit_train_done;
    logic          bit_train_fail;
    logic          bit_train_start;
    logic          qdr_w_n;
    logic          qdr_r_n;
    logic [AW-1:0] qdr_sa;
    logic [DW-1:0] qdr_d_rise;
    logic [DW-1:0] qdr_d_fall;
    logic [BW-1:0] qdr_bw_n;
    logic          train_done;
    logic          train_fail;
    logic [2:0]    state_prb;

    qdrc_phy_train_pattern_gen #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BW_WIDTH(BW), .TRAIN_ADDR(0),
        .SETTLE_CYCLES(SETTLE), .READ_LEAD(LEAD), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .train_start(train_start),
        .bit_train_done(bit_train_done), .bit_train_fail(bit_train_fail),
        .bit_train_start(bit_train_start), .qdr_w_n(qdr_w_n), .qdr_r_n(qdr_r_n),
        .qdr_sa(qdr_sa), .qdr_d_rise(qdr_d_rise), .qdr_d_fall(qdr_d_fall),
        .qdr_bw_n(qdr_bw_n), .train_done(train_done), .train_fail(train_fail),
        .state_prb(state_prb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: position within the sequence plus sticky status.
    bit m_busy = 1'b0;
    bit m_over = 1'b0;
    int m_k    = 0;
    bit m_done = 1'b0;
    bit m_fail = 1'b0;

    // Observation counters for the current sequence.
    int w_low, data_cyc, first_rd, pulse_cyc, pulses, reads;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_step();
        int nreads;
        if (reset) begin
            m_busy = 1'b0; m_over = 1'b0; m_k = 0; m_done = 1'b0; m_fail = 1'b0;
        end else if (m_busy) begin
            if (m_k >= READ_K0) begin
                nreads = m_k - READ_K0 + 1;
                if (bit_train_done && m_k >= PULSE_K) begin
                    m_busy = 1'b0; m_over = 1'b1; m_done = 1'b1; m_fail = bit_train_fail;
                end else if (nreads == TIMEOUT) begin
                    m_busy = 1'b0; m_over = 1'b1; m_done = 1'b1; m_fail = 1'b1;
                end
            end
            if (m_busy) m_k++;
        end else if (!m_over && train_start) begin
            m_busy = 1'b1;
            m_k    = 1;
        end
    endtask

    task automatic compare_all();
        logic [DW-1:0] ones_d;
        logic [BW-1:0] ones_bw;
        int            exp_state;
        ones_d  = '1;
        ones_bw = '1;
        if (m_over)              exp_state = 5;
        else if (!m_busy)        exp_state = 0;
        else if (m_k == 1)       exp_state = 1;
        else if (m_k == 2)       exp_state = 2;
        else if (m_k < READ_K0)  exp_state = 3;
        else                     exp_state = 4;
        check("w_n",   64'(qdr_w_n),    64'(!(m_busy && m_k == 1)));
        check("r_n",   64'(qdr_r_n),    64'(!(m_busy && m_k >= READ_K0)));
        check("sa",    64'(qdr_sa),     64'd0);
        check("d_rise", 64'(qdr_d_rise), (m_busy && m_k == 2) ? 64'(ones_d) : 64'd0);
        check("d_fall", 64'(qdr_d_fall), 64'd0);
        check("bw_n",  64'(qdr_bw_n),   (m_busy && (m_k == 1 || m_k == 2)) ? 64'd0 : 64'(ones_bw));
        check("bt_start", 64'(bit_train_start), 64'(m_busy && m_k == PULSE_K));
        check("train_done", 64'(train_done), 64'(m_done));
        check("train_fail", 64'(train_fail), 64'(m_fail));
        check("state", 64'(state_prb), 64'(exp_state));
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic step(input logic rst, input logic st, input logic dn, input logic fl);
        reset = rst; train_start = st; bit_train_done = dn; bit_train_fail = fl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
        if (!qdr_w_n) w_low++;
        if (qdr_d_rise != '0 && data_cyc < 0) data_cyc = cyc;
        if (!qdr_r_n) begin
            reads++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (bit_train_start) begin
            pulses++;
            pulse_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_state_lit", 64'(state_prb), 64'd0);
        check("rst_bw_lit",    64'(qdr_bw_n),  64'hF);
        check("rst_rn_lit",    64'(qdr_r_n),   64'd1);
    endtask

    // done_after: cycles after the start pulse to raise done (-1 = never).
    // reset_at: sequence position at which to assert reset (0 = none).
    task automatic run_seq(input int done_after, input logic fail_v,
                           input logic noise, input int reset_at);
        int  guard;
        bit  was_reset;
        logic dn, fl;
        int  exp_reads;
        bit  exp_fail;
        w_low = 0; data_cyc = -1; first_rd = -1; pulse_cyc = -1; pulses = 0; reads = 0;
        guard = 0; was_reset = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        while (m_busy && guard < 600) begin
            guard++;
            dn = 1'b0; fl = 1'b0;
            if (reset_at > 0 && m_k == reset_at) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                was_reset = 1'b1;
                check("cut_rn_lit", 64'(qdr_r_n), 64'd1);
                check("cut_state_lit", 64'(state_prb), 64'd0);
            end else begin
                if (done_after >= 0 && m_k >= PULSE_K + done_after) begin
                    dn = 1'b1; fl = fail_v;
                end else if (noise && m_k < PULSE_K) begin
                    dn = 1'($urandom_range(0, 1));
                    fl = 1'($urandom_range(0, 1));
                end
                step(1'b0, 1'b0, dn, fl);
            end
        end
        if (guard >= 600) check("seq_bound", 64'd1, 64'd0);
        if (!was_reset) begin
            if (done_after >= 0 && LEAD + 1 + done_after <= TIMEOUT) begin
                exp_reads = LEAD + 1 + done_after;
                exp_fail  = fail_v;
            end else begin
                exp_reads = TIMEOUT;
                exp_fail  = 1'b1;
            end
            check("w_low_cycles",   64'(w_low), 64'd1);
            check("settle_gap",     64'(first_rd - data_cyc), 64'd16);
            check("reads_to_pulse", 64'(pulse_cyc - first_rd + 1), 64'd33);
            check("pulse_count",    64'(pulses), 64'd1);
            check("read_count",     64'(reads), 64'(exp_reads));
            check("done_lit",       64'(train_done), 64'd1);
            check("fail_lit",       64'(train_fail), 64'(exp_fail));
            check("done_state_lit", 64'(state_prb), 64'd5);
            // train_start in DONE must not restart anything.
            for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("rearm_w_n_lit", 64'(qdr_w_n), 64'd1);
            check("rearm_w_low",   64'(w_low), 64'd1);
        end
    endtask

    initial begin
        reset = 1'b1; train_start = 1'b0; bit_train_done = 1'b0; bit_train_fail = 1'b0;
        do_reset();
        // train_start ignored while reset is held.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("hold_rst_w_n", 64'(qdr_w_n), 64'd1);

        // Nominal: done 100 cycles after the start pulse, no fail.
        do_reset();
        run_seq(100, 1'b0, 1'b0, 0);
        // Timeout: done never arrives.
        do_reset();
        run_seq(-1, 1'b0, 1'b0, 0);
        // Done with fail.
        do_reset();
        run_seq(10, 1'b1, 1'b0, 0);
        // Done arriving exactly on the pulse, with pre-pulse noise.
        do_reset();
        run_seq(0, 1'b0, 1'b1, 0);
        // Done on the last permitted read coincides with timeout: done wins.
        do_reset();
        run_seq(TIMEOUT - LEAD - 1, 1'b0, 1'b0, 0);
        // Reset during READ, then a clean repeat with identical timing.
        do_reset();
        run_seq(100, 1'b0, 1'b0, READ_K0 + 40);
        run_seq(100, 1'b0, 1'b0, 0);
        // Randomised sequences.
        for (int n = 0; n < 8; n++) begin
            int  d;
            int  ra;
            logic f;
            d  = int'($urandom_range(0, 220));
            f  = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 120)) : 0;
            do_reset();
            run_seq(d, f, 1'b1, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
